// File: rtl/posit_defines.sv
// rtl/posit_defines.sv - shared sizing helpers for the posit normaliser blocks
package posit_defines;

    // Width of a requester index for a C_REQ-way arbiter.
    function automatic int lod_norm_idx_w(input int c_req);
        return $clog2(c_req);
    endfunction

    // Width of a leading-zero count for a C_N-bit operand.
    function automatic int lod_norm_lzc_w(input int c_n);
        return $clog2(c_n);
    endfunction

endpackage

// File: rtl/lod_n.sv
// rtl/lod_n.sv - leading-one detector returning leading-zero count and zero flag
//
// Ports:
//   i_data  operand
//   o_lzc   zeros above the highest set bit (all ones when operand is zero)
//   o_zero  operand is all zeros
module lod_n
    import posit_defines::*;
#(
    parameter  int C_N   = 64,
    localparam int LZC_W = lod_norm_lzc_w(C_N)
) (
    input  logic [C_N-1:0]   i_data,
    output logic [LZC_W-1:0] o_lzc,
    output logic             o_zero
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        o_zero = 1'b1;
        o_lzc  = '1;
        for (int i = 0; i < C_N; i++) begin
            if (i_data[i]) begin
                o_zero = 1'b0;
                o_lzc  = LZC_W'(C_N - 1 - i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and index
//
// Ports:
//   clk        clock
//   i_rst      synchronous reset, active high (pointer returns to 0)
//   i_req      per-requester request
//   i_advance  a grant was taken this cycle; pointer moves past the winner
//   o_grant    one-hot grant (zero when no request)
//   o_idx      index of the granted requester
module rr_arbiter
    import posit_defines::*;
#(
    parameter  int C_REQ = 4,
    localparam int IDX_W = lod_norm_idx_w(C_REQ)
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic [C_REQ-1:0] i_req,
    input  logic             i_advance,
    output logic [C_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;

    // First requester at or after the pointer, wrapping modulo C_REQ.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < C_REQ; k++) begin
            if (!w_found && i_req[(int'(r_ptr) + k) % C_REQ]) begin
                w_found = 1'b1;
                o_grant[(int'(r_ptr) + k) % C_REQ] = 1'b1;
                o_idx = IDX_W'((int'(r_ptr) + k) % C_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_idx == IDX_W'(C_REQ - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/lod_norm_sched.sv
// rtl/lod_norm_sched.sv - round-robin shared leading-one normaliser, 3-stage pipeline
//
// Ports:
//   clk, rst                synchronous active-high reset
//   req_valid/ready/data    per-requester operand handshake
//   out_valid/ready         result handshake
//   out_data                operand shifted so its leading one sits at the MSB
//   out_lzc, out_zero       leading-zero count and all-zero flag
//   out_id                  requester index of the result
//   busy                    any stage holds an item
module lod_norm_sched
    import posit_defines::*;
#(
    parameter  int C_N   = 64,
    parameter  int C_REQ = 4,
    localparam int LZC_W = lod_norm_lzc_w(C_N),
    localparam int IDX_W = lod_norm_idx_w(C_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [C_REQ-1:0]          req_valid,
    output logic [C_REQ-1:0]          req_ready,
    input  logic [C_REQ-1:0][C_N-1:0] req_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [C_N-1:0]            out_data,
    output logic [LZC_W-1:0]          out_lzc,
    output logic                      out_zero,
    output logic [IDX_W-1:0]          out_id,
    output logic                      busy
);

    typedef struct packed {
        logic [C_N-1:0]   data;
        logic [LZC_W-1:0] lzc;
        logic             zero;
        logic [IDX_W-1:0] id;
    } payload_t;

    logic             r_s1_valid;
    logic [C_N-1:0]   r_s1_data;
    logic [IDX_W-1:0] r_s1_id;
    logic             r_s2_valid;
    payload_t         r_s2;
    logic             r_s3_valid;
    payload_t         r_s3;

    logic             w_adv1, w_adv2, w_adv3;
    logic             w_any_req, w_xfer;
    logic [C_REQ-1:0] w_grant;
    logic [IDX_W-1:0] w_idx;
    logic [LZC_W-1:0] w_lzc;
    logic             w_zero;

    // A stage loads when it is empty or its successor loads this cycle.
    assign w_adv3    = !r_s3_valid || out_ready;
    assign w_adv2    = !r_s2_valid || w_adv3;
    assign w_adv1    = !r_s1_valid || w_adv2;
    assign w_any_req = |req_valid;
    assign w_xfer    = w_adv1 && w_any_req && !rst;
    assign req_ready = (w_adv1 && !rst) ? w_grant : '0;

    rr_arbiter #(.C_REQ(C_REQ)) u_arb (
        .clk      (clk),
        .i_rst    (rst),
        .i_req    (req_valid),
        .i_advance(w_xfer),
        .o_grant  (w_grant),
        .o_idx    (w_idx)
    );

    lod_n #(.C_N(C_N)) u_lod (
        .i_data(r_s1_data),
        .o_lzc (w_lzc),
        .o_zero(w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
            r_s3_valid <= 1'b0;
            r_s3       <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= w_any_req;
                r_s1_data  <= req_data[w_idx];
                r_s1_id    <= w_idx;
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                r_s2.data  <= r_s1_data;
                r_s2.lzc   <= w_lzc;
                r_s2.zero  <= w_zero;
                r_s2.id    <= r_s1_id;
            end
            if (w_adv3) begin
                r_s3_valid <= r_s2_valid;
                // Zero operand shifts by all ones, which still yields zero.
                r_s3.data  <= r_s2.data << r_s2.lzc;
                r_s3.lzc   <= r_s2.lzc;
                r_s3.zero  <= r_s2.zero;
                r_s3.id    <= r_s2.id;
            end
        end
    end

    assign out_valid = r_s3_valid;
    assign out_data  = r_s3.data;
    assign out_lzc   = r_s3.lzc;
    assign out_zero  = r_s3.zero;
    assign out_id    = r_s3.id;
    assign busy      = r_s1_valid || r_s2_valid || r_s3_valid;

endmodule

// File: tb/tb_lod_norm_sched.sv
// tb/tb_lod_norm_sched.sv - directed self-checking bench for lod_norm_sched
module tb_lod_norm_sched;

    logic             clk = 1'b0;
    logic             rst;

    logic [3:0]       a_req_valid, a_req_ready;
    logic [3:0][63:0] a_req_data;
    logic             a_out_valid, a_out_ready, a_out_zero, a_busy;
    logic [63:0]      a_out_data;
    logic [5:0]       a_out_lzc;
    logic [1:0]       a_out_id;

    logic [3:0]       b_req_valid, b_req_ready;
    logic [3:0][39:0] b_req_data;
    logic             b_out_valid, b_out_ready, b_out_zero, b_busy;
    logic [39:0]      b_out_data;
    logic [5:0]       b_out_lzc;
    logic [1:0]       b_out_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lod_norm_sched #(.C_N(64), .C_REQ(4)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_data(a_req_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_lzc(a_out_lzc), .out_zero(a_out_zero), .out_id(a_out_id), .busy(a_busy)
    );

    lod_norm_sched #(.C_N(40), .C_REQ(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_data(b_req_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_lzc(b_out_lzc), .out_zero(b_out_zero), .out_id(b_out_id), .busy(b_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        a_req_valid = '0;
        b_req_valid = '0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_req_valid = 4'hF;
        b_req_valid = '0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) a_req_data[i] = 64'h1;
        #1;
        checks++; if (a_req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %h exp 0", a_req_ready); end
        tick();
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
        checks++; if (a_out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", a_out_data); end
        checks++; if (a_out_lzc !== 6'h0) begin errors++; $display("FAIL reset_out_lzc got %h exp 0", a_out_lzc); end
        checks++; if (a_out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got %b exp 0", a_out_zero); end
        checks++; if (a_out_id !== 2'h0) begin errors++; $display("FAIL reset_out_id got %h exp 0", a_out_id); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid got %b exp 0", b_out_valid); end
        a_req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single;
        do_reset();
        a_req_data[0] = 64'h0000_0000_0000_0F00;
        a_req_valid = 4'b0001;
        #1;
        checks++; if (a_req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %h exp 1", a_req_ready); end
        tick();
        a_req_valid = '0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_early1 got %b exp 0", a_out_valid); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", a_busy); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_early2 got %b exp 0", a_out_valid); end
        tick();
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", a_out_valid); end
        checks++; if (a_out_lzc !== 6'd52) begin errors++; $display("FAIL single_lzc got %0d exp 52", a_out_lzc); end
        checks++; if (a_out_data !== 64'hF000_0000_0000_0000) begin errors++; $display("FAIL single_data got %h exp f000000000000000", a_out_data); end
        checks++; if (a_out_id !== 2'd0 || a_out_zero !== 1'b0) begin errors++; $display("FAIL single_id_zero got %0d/%b exp 0/0", a_out_id, a_out_zero); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_after got %b exp 0", a_out_valid); end
    endtask

    task automatic test_round_robin;
        logic [63:0] exp_d [4];
        logic [5:0]  exp_l [4];
        logic [3:0]  exp_rdy;
        int          j;
        exp_d[0] = 64'hF000_0000_0000_0000; exp_l[0] = 6'd52;
        exp_d[1] = 64'h8000_0000_0000_0000; exp_l[1] = 6'd31;
        exp_d[2] = 64'hC000_0000_0000_0000; exp_l[2] = 6'd62;
        exp_d[3] = 64'h8000_0000_0000_0001; exp_l[3] = 6'd0;
        do_reset();
        a_req_data[0] = 64'h0000_0000_0000_0F00;
        a_req_data[1] = 64'h0000_0001_0000_0000;
        a_req_data[2] = 64'h0000_0000_0000_0003;
        a_req_data[3] = 64'h8000_0000_0000_0001;
        for (int c = 0; c < 10; c++) begin
            a_req_valid = (c < 6) ? 4'hF : 4'h0;
            #1;
            if (c < 6) begin
                exp_rdy = 4'(1 << (c % 4));
                checks++; if (a_req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant c=%0d got %b exp %b", c, a_req_ready, exp_rdy); end
            end
            tick();
            if (c >= 2 && c <= 7) begin
                j = (c - 2) % 4;
                checks++;
                if (a_out_valid !== 1'b1 || a_out_id !== 2'(j) || a_out_data !== exp_d[j] || a_out_lzc !== exp_l[j]) begin
                    errors++;
                    $display("FAIL rr_out c=%0d got v=%b id=%0d d=%h l=%0d exp v=1 id=%0d d=%h l=%0d",
                             c, a_out_valid, a_out_id, a_out_data, a_out_lzc, j, exp_d[j], exp_l[j]);
                end
            end else begin
                checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rr_idle c=%0d got %b exp 0", c, a_out_valid); end
            end
        end
    endtask

    task automatic test_zero;
        do_reset();
        a_req_data[2] = 64'h0;
        a_req_valid = 4'b0100;
        #1;
        checks++; if (a_req_ready !== 4'b0100) begin errors++; $display("FAIL zero_ready got %b exp 0100", a_req_ready); end
        tick();
        a_req_valid = '0;
        tick();
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_out_zero !== 1'b1) begin errors++; $display("FAIL zero_flag got v=%b z=%b exp 1/1", a_out_valid, a_out_zero); end
        checks++; if (a_out_lzc !== 6'h3F) begin errors++; $display("FAIL zero_lzc got %h exp 3f", a_out_lzc); end
        checks++; if (a_out_data !== 64'h0 || a_out_id !== 2'd2) begin errors++; $display("FAIL zero_data_id got %h/%0d exp 0/2", a_out_data, a_out_id); end
    endtask

    task automatic test_stall;
        logic [3:0] exp_rdy;
        int         n_acc;
        n_acc = 0;
        do_reset();
        a_req_data[0] = 64'h0000_0000_0000_0F00;
        a_req_data[1] = 64'h0000_0001_0000_0000;
        a_req_data[2] = 64'h0000_0000_0000_0003;
        a_req_data[3] = 64'h8000_0000_0000_0001;
        a_out_ready = 1'b0;
        a_req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_rdy = (c < 3) ? 4'(1 << c) : 4'h0;
            checks++; if (a_req_ready !== exp_rdy) begin errors++; $display("FAIL stall_ready c=%0d got %b exp %b", c, a_req_ready, exp_rdy); end
            if (a_req_ready != 4'h0) n_acc++;
            tick();
            if (c >= 2) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_id !== 2'd0 || a_out_data !== 64'hF000_0000_0000_0000 || a_out_lzc !== 6'd52) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d got v=%b id=%0d d=%h l=%0d exp v=1 id=0 d=f000000000000000 l=52",
                             c, a_out_valid, a_out_id, a_out_data, a_out_lzc);
                end
            end
        end
        checks++; if (n_acc !== 3) begin errors++; $display("FAIL stall_accepts got %0d exp 3", n_acc); end
        a_req_valid = '0;
        a_out_ready = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b1 || a_out_id !== 2'd0) begin errors++; $display("FAIL drain0 got v=%b id=%0d exp 1/0", a_out_valid, a_out_id); end
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_out_id !== 2'd1 || a_out_data !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL drain1 got v=%b id=%0d d=%h exp 1/1/8000000000000000", a_out_valid, a_out_id, a_out_data); end
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_out_id !== 2'd2 || a_out_data !== 64'hC000_0000_0000_0000) begin errors++; $display("FAIL drain2 got v=%b id=%0d d=%h exp 1/2/c000000000000000", a_out_valid, a_out_id, a_out_data); end
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL drain_end got v=%b busy=%b exp 0/0", a_out_valid, a_busy); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        a_req_data[1] = 64'h0000_0000_0000_1234;
        a_req_valid = 4'b0010;
        #1;
        checks++; if (a_req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ready got %b exp 0010", a_req_ready); end
        tick();
        a_req_valid = '0;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", a_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL mid_flush c=%0d got v=%b busy=%b exp 0/0", c, a_out_valid, a_busy); end
            tick();
        end
        a_req_data[0] = 64'h0000_0000_0000_0001;
        a_req_valid = 4'b0011;
        #1;
        checks++; if (a_req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first got %b exp 0001", a_req_ready); end
        tick();
        a_req_valid = 4'b0010;
        #1;
        checks++; if (a_req_ready !== 4'b0010) begin errors++; $display("FAIL mid_second got %b exp 0010", a_req_ready); end
        tick();
        a_req_valid = '0;
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_out_id !== 2'd0 || a_out_data !== 64'h8000_0000_0000_0000 || a_out_lzc !== 6'd63) begin errors++; $display("FAIL mid_out0 got v=%b id=%0d d=%h l=%0d exp 1/0/8000000000000000/63", a_out_valid, a_out_id, a_out_data, a_out_lzc); end
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_out_id !== 2'd1 || a_out_data !== 64'h91A0_0000_0000_0000 || a_out_lzc !== 6'd51) begin errors++; $display("FAIL mid_out1 got v=%b id=%0d d=%h l=%0d exp 1/1/91a0000000000000/51", a_out_valid, a_out_id, a_out_data, a_out_lzc); end
    endtask

    task automatic test_c40;
        logic [39:0] exp_d [3];
        logic [5:0]  exp_l [3];
        logic        exp_z [3];
        logic [3:0]  exp_rdy;
        exp_d[0] = 40'h80_0000_0000; exp_l[0] = 6'd39; exp_z[0] = 1'b0;
        exp_d[1] = 40'h80_0000_0000; exp_l[1] = 6'd0;  exp_z[1] = 1'b0;
        exp_d[2] = 40'h00_0000_0000; exp_l[2] = 6'h3F; exp_z[2] = 1'b1;
        do_reset();
        b_req_data[0] = 40'h00_0000_0001;
        b_req_data[1] = 40'h80_0000_0000;
        b_req_data[2] = 40'h00_0000_0000;
        b_req_data[3] = 40'h00_0000_0000;
        for (int k = 0; k < 3; k++) begin
            exp_rdy = 4'(1 << k);
            b_req_valid = exp_rdy;
            #1;
            checks++; if (b_req_ready !== exp_rdy) begin errors++; $display("FAIL c40_ready k=%0d got %b exp %b", k, b_req_ready, exp_rdy); end
            tick();
            b_req_valid = '0;
            tick();
            tick();
            checks++;
            if (b_out_valid !== 1'b1 || b_out_id !== 2'(k) || b_out_data !== exp_d[k] || b_out_lzc !== exp_l[k] || b_out_zero !== exp_z[k]) begin
                errors++;
                $display("FAIL c40_out k=%0d got v=%b id=%0d d=%h l=%0d z=%b exp v=1 id=%0d d=%h l=%0d z=%b",
                         k, b_out_valid, b_out_id, b_out_data, b_out_lzc, b_out_zero, k, exp_d[k], exp_l[k], exp_z[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = '0;
        a_req_data  = '0;
        a_out_ready = 1'b1;
        b_req_valid = '0;
        b_req_data  = '0;
        b_out_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_zero();
        test_stall();
        test_reset_mid();
        test_c40();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
